// File: rtl/reduce_stream_if.sv
// Handshake bundle for reduce_stream: input word stream and registered frame-result stream.
// REDUCE_STREAM_POPCOUNT_EN adds the out_ones result field.
interface reduce_stream_if #(
  parameter int WIDTH     = 4,
  parameter int FRAME_LEN = 4
);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [5:0]       out_all;
  logic [CNT_W-1:0] out_words;
`ifdef REDUCE_STREAM_POPCOUNT_EN
  localparam int ONES_W = $clog2(WIDTH * FRAME_LEN + 1);
  logic [ONES_W-1:0] out_ones;
`endif

  // The engine side of the bundle.
  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_all,
    output out_words
`ifdef REDUCE_STREAM_POPCOUNT_EN
    , output out_ones
`endif
  );

  // The producer/consumer side of the bundle.
  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_all,
    input  out_words
`ifdef REDUCE_STREAM_POPCOUNT_EN
    , input out_ones
`endif
  );
endinterface

// File: rtl/reduce_stream.sv
// Streaming frame reducer: AND/OR/XOR over every bit of up to FRAME_LEN words, result held until consumed.
// Optional REDUCE_STREAM_POPCOUNT_EN also reports the number of 1 bits in the frame.
module reduce_stream #(
  parameter int WIDTH     = 4,
  parameter int FRAME_LEN = 4
) (
  input  logic          clk,
  input  logic          rst,
  reduce_stream_if.slave bus
);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]       stateReg;
  logic             andAcc;
  logic             orAcc;
  logic             xorAcc;
  logic [CNT_W-1:0] beatCount;

  logic             accept;
  logic             wordAnd;
  logic             wordOr;
  logic             wordXor;
  logic             andNext;
  logic             orNext;
  logic             xorNext;
  logic [CNT_W-1:0] countNext;
  logic             frameDone;
  logic             firstBeat;

  assign bus.in_ready = (stateReg != HOLD);
  assign accept       = bus.in_valid && bus.in_ready;
  assign firstBeat    = (stateReg == IDLE);

  assign wordAnd = &bus.in_data;
  assign wordOr  = |bus.in_data;
  assign wordXor = ^bus.in_data;

  // The first beat of a frame seeds the accumulators instead of merging into them.
  assign andNext   = firstBeat ? wordAnd : (andAcc & wordAnd);
  assign orNext    = firstBeat ? wordOr  : (orAcc | wordOr);
  assign xorNext   = firstBeat ? wordXor : (xorAcc ^ wordXor);
  assign countNext = firstBeat ? CNT_W'(1) : (beatCount + CNT_W'(1));
  assign frameDone = bus.in_last || (countNext == CNT_W'(FRAME_LEN));

`ifdef REDUCE_STREAM_POPCOUNT_EN
  localparam int ONES_W = $clog2(WIDTH * FRAME_LEN + 1);

  logic [ONES_W-1:0] onesAcc;
  logic [ONES_W-1:0] wordOnes;
  logic [ONES_W-1:0] onesNext;

  always_comb begin
    wordOnes = '0;
    for (int i = 0; i < WIDTH; i++) begin
      wordOnes = wordOnes + ONES_W'(bus.in_data[i]);
    end
  end

  assign onesNext = firstBeat ? wordOnes : (onesAcc + wordOnes);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg      <= IDLE;
      andAcc        <= 1'b1;
      orAcc         <= 1'b0;
      xorAcc        <= 1'b0;
      beatCount     <= '0;
      bus.out_valid <= 1'b0;
      bus.out_all   <= '0;
      bus.out_words <= '0;
`ifdef REDUCE_STREAM_POPCOUNT_EN
      onesAcc       <= '0;
      bus.out_ones  <= '0;
`endif
    end else begin
      case (stateReg)
        IDLE, ACCUM: begin
          if (accept) begin
            andAcc    <= andNext;
            orAcc     <= orNext;
            xorAcc    <= xorNext;
            beatCount <= countNext;
`ifdef REDUCE_STREAM_POPCOUNT_EN
            onesAcc   <= onesNext;
`endif
            if (frameDone) begin
              // Result is captured from the merged values so the last beat is included.
              stateReg      <= HOLD;
              bus.out_valid <= 1'b1;
              bus.out_all   <= {~xorNext, xorNext, ~orNext, orNext, ~andNext, andNext};
              bus.out_words <= countNext;
`ifdef REDUCE_STREAM_POPCOUNT_EN
              bus.out_ones  <= onesNext;
`endif
            end else begin
              stateReg <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            stateReg      <= IDLE;
            bus.out_valid <= 1'b0;
            andAcc        <= 1'b1;
            orAcc         <= 1'b0;
            xorAcc        <= 1'b0;
            beatCount     <= '0;
`ifdef REDUCE_STREAM_POPCOUNT_EN
            onesAcc       <= '0;
`endif
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reduce_stream.sv
// Randomized + directed bench for reduce_stream: frame-level scoreboard on a FRAME_LEN=4 and a FRAME_LEN=1 instance.
module tb_reduce_stream;
  typedef struct {
    logic [5:0] all;
    int         words;
    int         ones;
  } exp_t;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst1 = 1'b1;
  bit   randReady = 1'b0;
  bit   done1 = 1'b0;

  int checkCount = 0;
  int passCount  = 0;

  logic [3:0] curBeat [2][$];
  exp_t       expQ    [2][$];

  always #5 clk = ~clk;

  reduce_stream_if #(.WIDTH(4), .FRAME_LEN(4)) bus0 ();
  reduce_stream_if #(.WIDTH(4), .FRAME_LEN(1)) bus1 ();

  reduce_stream #(.WIDTH(4), .FRAME_LEN(4)) u0 (.clk(clk), .rst(rst),  .bus(bus0));
  reduce_stream #(.WIDTH(4), .FRAME_LEN(1)) u1 (.clk(clk), .rst(rst1), .bus(bus1));

  int ones0;
  int ones1;
`ifdef REDUCE_STREAM_POPCOUNT_EN
  assign ones0 = int'(bus0.out_ones);
  assign ones1 = int'(bus1.out_ones);
`else
  assign ones0 = 0;
  assign ones1 = 0;
`endif

  task automatic checkValue(input string tag, input longint got, input longint want);
    checkCount++;
    if (got == want) passCount++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, want, want, $time);
  endtask

  // Frame result derived from the total bit population of the frame.
  function automatic exp_t refResult(input logic [3:0] beats[$]);
    exp_t r;
    int   ones = 0;
    int   nBits = beats.size() * 4;
    logic a, o, x;
    foreach (beats[i]) for (int b = 0; b < 4; b++) ones += int'(beats[i][b]);
    a = (ones == nBits);
    o = (ones > 0);
    x = ((ones % 2) == 1);
    r.all   = {~x, x, ~o, o, ~a, a};
    r.words = beats.size();
    r.ones  = ones;
    return r;
  endfunction

  task automatic scoreStep(input int id, input int flen, input bit r,
                           input bit inV, input bit inR, input logic [3:0] inD, input bit inL,
                           input bit outV, input bit outR, input logic [5:0] outAll,
                           input int outWords, input int outOnes);
    string p;
    p = (id == 0) ? "fl4" : "fl1";
    if (r) begin
      curBeat[id].delete();
      expQ[id].delete();
      return;
    end
    checkValue({p, "_out_valid"}, longint'(outV), longint'(expQ[id].size() != 0));
    checkValue({p, "_in_ready"}, longint'(inR), longint'(!outV));
    if (outV && expQ[id].size() != 0) begin
      checkValue({p, "_out_all"}, longint'(outAll), longint'(expQ[id][0].all));
      checkValue({p, "_out_words"}, longint'(outWords), longint'(expQ[id][0].words));
`ifdef REDUCE_STREAM_POPCOUNT_EN
      checkValue({p, "_out_ones"}, longint'(outOnes), longint'(expQ[id][0].ones));
`endif
      if (outR) void'(expQ[id].pop_front());
    end
    if (inV && inR) begin
      curBeat[id].push_back(inD);
      if (inL || curBeat[id].size() == flen) begin
        expQ[id].push_back(refResult(curBeat[id]));
        curBeat[id].delete();
      end
    end
  endtask

  always @(negedge clk)
    scoreStep(0, 4, rst, bus0.in_valid, bus0.in_ready, bus0.in_data, bus0.in_last,
              bus0.out_valid, bus0.out_ready, bus0.out_all, int'(bus0.out_words), ones0);

  always @(negedge clk)
    scoreStep(1, 1, rst1, bus1.in_valid, bus1.in_ready, bus1.in_data, bus1.in_last,
              bus1.out_valid, bus1.out_ready, bus1.out_all, int'(bus1.out_words), ones1);

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (randReady) bus0.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic sendBeat(input logic [3:0] d, input bit last);
    int n = 0;
    bit ok = 1'b0;
    bus0.in_valid = 1'b1;
    bus0.in_data  = d;
    bus0.in_last  = last;
    do begin
      @(negedge clk);
      ok = bus0.in_ready;
      n++;
      @(posedge clk);
      #1;
    end while (!ok && n < 100);
    if (!ok) checkValue("accept_timeout", 0, 1);
    bus0.in_valid = 1'b0;
    bus0.in_last  = 1'b0;
    bus0.in_data  = 4'($urandom);
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic expectResult(input string tag, input logic [5:0] a, input int w, input int o);
    @(negedge clk);
    checkValue({tag, "_valid"}, longint'(bus0.out_valid), 1);
    checkValue({tag, "_all"}, longint'(bus0.out_all), longint'(a));
    checkValue({tag, "_words"}, longint'(bus0.out_words), longint'(w));
`ifdef REDUCE_STREAM_POPCOUNT_EN
    checkValue({tag, "_ones"}, longint'(ones0), longint'(o));
`else
    if (o < 0) checkValue({tag, "_ones"}, longint'(ones0), longint'(o));
`endif
    @(posedge clk);
    #1;
  endtask

  // FRAME_LEN=1 instance: continuous valid gives one result every two cycles.
  initial begin
    int cnt = 0;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = 4'b0111;
    bus1.in_last   = 1'b0;
    bus1.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst1 = 1'b0;
    @(negedge clk);
    checkValue("fl1_reset_valid", longint'(bus1.out_valid), 0);
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus1.out_valid) begin
        cnt++;
        checkValue("fl1_all", longint'(bus1.out_all), longint'(6'b010110));
        checkValue("fl1_words", longint'(bus1.out_words), 1);
      end
      @(posedge clk);
      #1;
    end
    checkValue("fl1_period", longint'(cnt), 10);
    bus1.in_valid = 1'b0;
    done1 = 1'b1;
  end

  initial begin
    logic [3:0] d;
    bus0.in_valid  = 1'b0;
    bus0.in_data   = 4'h0;
    bus0.in_last   = 1'b0;
    bus0.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    checkValue("reset_out_valid", longint'(bus0.out_valid), 0);
    checkValue("reset_out_all", longint'(bus0.out_all), 0);
    checkValue("reset_out_words", longint'(bus0.out_words), 0);
    checkValue("reset_in_ready", longint'(bus0.in_ready), 1);
    checkValue("reset_out_ones", longint'(ones0), 0);
    @(posedge clk);
    #1;

    // Ascending frame, consumed immediately.
    for (int i = 0; i < 4; i++) sendBeat(4'(i), 1'b0);
    expectResult("asc", 6'b100110, 4, 4);
    @(negedge clk);
    checkValue("asc_after_valid", longint'(bus0.out_valid), 0);
    checkValue("asc_after_ready", longint'(bus0.in_ready), 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) sendBeat(4'hF, 1'b0);
    expectResult("ones", 6'b100101, 4, 16);

    sendBeat(4'b0001, 1'b0);
    sendBeat(4'b0011, 1'b1);
    expectResult("short", 6'b010110, 2, 3);
    for (int i = 0; i < 4; i++) sendBeat(4'hF, 1'b0);
    expectResult("after_short", 6'b100101, 4, 16);

    // Backpressure: result must hold while beats are offered and refused.
    bus0.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) sendBeat(4'(i), 1'b0);
    bus0.in_valid = 1'b1;
    bus0.in_data  = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkValue("bp_valid", longint'(bus0.out_valid), 1);
      checkValue("bp_all", longint'(bus0.out_all), longint'(6'b100110));
      checkValue("bp_in_ready", longint'(bus0.in_ready), 0);
      @(posedge clk);
      #1;
    end
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkValue("bp_release_valid", longint'(bus0.out_valid), 0);
    checkValue("bp_release_ready", longint'(bus0.in_ready), 1);
    @(posedge clk);
    #1;

    // Reset mid-frame discards the partial frame.
    sendBeat(4'hF, 1'b0);
    sendBeat(4'hF, 1'b0);
    doReset();
    for (int i = 0; i < 4; i++) sendBeat(4'h0, 1'b0);
    expectResult("post_reset", 6'b101010, 4, 0);

    // Random traffic with random backpressure, gaps, short frames and rare resets.
    randReady = 1'b1;
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 59) == 0) doReset();
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      case ($urandom_range(0, 3))
        0: d = 4'hF;
        1: d = 4'h0;
        default: d = 4'($urandom);
      endcase
      sendBeat(d, $urandom_range(0, 3) == 0);
    end
    randReady = 1'b0;
    bus0.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkValue("drain_pending", longint'(expQ[0].size()), 0);

    wait (done1);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/reduce_stream.md
Name: reduce_stream

Overview:
- Streaming reduction engine. Accepts WIDTH-bit words over a valid/ready handshake and reduces all bits of a frame to the six reduction results (AND, NAND, OR, NOR, XOR, XNOR).
- A frame ends after FRAME_LEN beats or on an early `in_last`.
- The result is presented on a registered output handshake. It is the parametrised, multi-word, flow-controlled successor to the team's single-word combinational reduction block.
- Used for frame-level parity and all-ones/all-zeros detection.

Parameters:
- WIDTH, 4, bits per input word (>=1)
- FRAME_LEN, 4, maximum beats per frame (>=1)
- CNT_W, $clog2(FRAME_LEN+1), derived (localparam), width of the beat counter and `out_words`

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept a word
- in_data  input  WIDTH  input word
- in_last  input  1  marks the final beat of a short frame (ignored unless the beat is accepted)
- out_valid  output  1  frame result valid
- out_ready  input  1  downstream accepts result
- out_all  output  6  {xnor, xor, nor, or, nand, and} over all frame bits
- out_words  output  CNT_W  number of beats in the reported frame (1..FRAME_LEN)

Behaviour:
- Reset, synchronous on `clk` while `rst`=1:
  - state=IDLE, `out_valid`=0, `out_all`=0, `out_words`=0.
  - Accumulators: and_acc=1, or_acc=0, xor_acc=0. Beat count=0.
  - `rst` dominates all other inputs in the same cycle.
- Handshakes:
  - A beat is accepted when `in_valid && in_ready`.
  - A result is consumed when `out_valid && out_ready`.
- `in_ready` = (state != HOLD), combinational from state only. There is no skid buffer.
- States:
  - IDLE: no beats yet. On accept: and_acc=&in_data, or_acc=|in_data, xor_acc=^in_data, count=1. If `in_last` or FRAME_LEN==1, go to HOLD, else go to ACCUM.
  - ACCUM: on accept: and_acc&=&in_data, or_acc|=|in_data, xor_acc^=^in_data, count+=1. If `in_last` or count+1==FRAME_LEN, go to HOLD. With no accept, all state holds.
  - HOLD: `out_valid`=1. `out_all` and `out_words` are registered on the HOLD entry edge from the final accumulator values, with nand/nor/xnor as inverses. On consume, go to IDLE and clear `out_valid` the next cycle.
- Latency: `out_valid` rises on the cycle after the last beat is accepted. Minimum frame period is N+1 cycles for N beats.
- Backpressure: while `out_valid` && !`out_ready`, `out_all`/`out_words` stay stable and `in_ready`=0.
- `in_last` on beat FRAME_LEN: same as a count-terminated frame, with no extra beat.
- `in_data` containing X/Z is unspecified; the bench drives known values only.
- Reset mid-frame: the partial frame is discarded and no result is emitted.
- `out_all`/`out_words` keep their last value after consume until the next HOLD entry.

Optional Feature:
- Macro: REDUCE_STREAM_POPCOUNT_EN.
- Defined:
  - Adds output port `out_ones`, width $clog2(WIDTH*FRAME_LEN+1): the count of 1 bits across all accepted beats of the frame.
  - Accumulated alongside the other accumulators, registered on HOLD entry with the same timing and stability as `out_all`, reset to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=4, FRAME_LEN=4; beats 4'h0, 4'h1, 4'h2, 4'h3 back-to-back, `out_ready`=1 -> one cycle after beat 4: `out_valid`=1, `out_all`=6'b100110, `out_words`=4, `out_ones`=4 (if enabled); `in_ready`=0 for exactly that cycle.
- Four beats of 4'hF -> `out_all`=6'b100101, `out_words`=4, `out_ones`=16.
- Beats 4'b0001, 4'b0011 with `in_last` on beat 2 -> `out_all`=6'b010110, `out_words`=2, `out_ones`=3; the next beat starts a fresh frame.
- Frame 0,1,2,3 with `out_ready`=0 for 5 cycles -> `out_valid`=1 and `out_all`=6'b100110 held for 5 cycles, `in_ready`=0 throughout, offered `in_valid` beats not accepted. After `out_ready`=1: `out_valid`=0 next cycle, `in_ready`=1.
- Two beats of 4'hF, assert `rst` 1 cycle, then four beats of 4'h0 -> no result for the aborted frame. Next result: `out_all`=6'b101010, `out_words`=4, `out_ones`=0.
- FRAME_LEN=1 instance; beat 4'b0111 -> `out_all`=6'b010110, `out_words`=1 on the next cycle; `in_valid` held high yields one result every 2 cycles.
